// File: rtl/stroke_if.sv
// Bundle between the stroke-table playback sequencer, its controller, the stroke table
// and the plotter drivers.
interface stroke_if;
    logic       start;
    logic [4:0] seg_count;
    logic [4:0] seg_idx;
    logic       seg_en;
    logic [7:0] seg_start_x;
    logic [7:0] seg_start_y;
    logic [7:0] seg_end_x;
    logic [7:0] seg_end_y;
    logic       seg_pen_down;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic       pen;
    logic       step_x;
    logic       step_y;
    logic       dir_x;
    logic       dir_y;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output start, seg_count, seg_start_x, seg_start_y, seg_end_x, seg_end_y, seg_pen_down,
        input  seg_idx, seg_en, pos_x, pos_y, pen, step_x, step_y, dir_x, dir_y, busy, done, err
    );

    modport slave (
        input  start, seg_count, seg_start_x, seg_start_y, seg_end_x, seg_end_y, seg_pen_down,
        output seg_idx, seg_en, pos_x, pos_y, pen, step_x, step_y, dir_x, dir_y, busy, done, err
    );
endinterface

// File: rtl/stroke_player.sv
// Stroke-table sequencer: walks segments, commands the pen servo and emits X/Y step
// pulses, one unit per axis per motion tick.
module stroke_player #(
    parameter int TICK_DIV   = 100000,
    parameter int PEN_SETTLE = 50
) (
    input  logic    clk,
    input  logic    rst,
    stroke_if.slave bus
);
    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | latch segment end point and pen state, check start point
    // PEN   | pen changed, waiting PEN_SETTLE ticks for the servo
    // MOVE  | stepping toward the target on each tick
    // NEXT  | advance segment index or finish
    // DONE  | pulse done, return to IDLE
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PEN, S_MOVE, S_NEXT, S_DONE} state_t;

    localparam int DW = $clog2(TICK_DIV);
    localparam int SW = $clog2(PEN_SETTLE + 1);

    state_t          state, state_nxt;
    logic [DW-1:0]   div;
    logic [SW-1:0]   settle, settle_nxt;
    logic [4:0]      seg_idx, idx_nxt, cnt_lat, cnt_nxt;
    logic [7:0]      tgt_x, tgt_y, tx_nxt, ty_nxt;
    logic [7:0]      pos_x, pos_y, px_nxt, py_nxt;
    logic            pen, pen_nxt;
    logic            step_x, step_y, sx_nxt, sy_nxt;
    logic            dir_x, dir_y, dx_nxt, dy_nxt;
    logic            err, err_nxt;
    logic            done, done_nxt;
    logic            busy, tick;

    assign busy = (state != S_IDLE);
    assign tick = busy && (div == DW'(TICK_DIV - 1));

    // Divider restarts on every LOAD so each segment's first tick is a full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              div <= '0;
        else if (!busy || state_nxt == S_LOAD) div <= '0;
        else if (tick)                        div <= '0;
        else                                  div <= div + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            settle  <= '0;
            seg_idx <= '0;
            cnt_lat <= '0;
            tgt_x   <= '0;
            tgt_y   <= '0;
            pos_x   <= '0;
            pos_y   <= '0;
            pen     <= 1'b0;
            step_x  <= 1'b0;
            step_y  <= 1'b0;
            dir_x   <= 1'b0;
            dir_y   <= 1'b0;
            err     <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            settle  <= settle_nxt;
            seg_idx <= idx_nxt;
            cnt_lat <= cnt_nxt;
            tgt_x   <= tx_nxt;
            tgt_y   <= ty_nxt;
            pos_x   <= px_nxt;
            pos_y   <= py_nxt;
            pen     <= pen_nxt;
            step_x  <= sx_nxt;
            step_y  <= sy_nxt;
            dir_x   <= dx_nxt;
            dir_y   <= dy_nxt;
            err     <= err_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        settle_nxt = settle;
        idx_nxt    = seg_idx;
        cnt_nxt    = cnt_lat;
        tx_nxt     = tgt_x;
        ty_nxt     = tgt_y;
        px_nxt     = pos_x;
        py_nxt     = pos_y;
        pen_nxt    = pen;
        sx_nxt     = 1'b0;
        sy_nxt     = 1'b0;
        dx_nxt     = dir_x;
        dy_nxt     = dir_y;
        err_nxt    = err;
        done_nxt   = 1'b0;
        case (state)
            S_IDLE: begin
                // done is high in the first IDLE cycle; a start coinciding with it is dropped
                if (bus.start && !done) begin
                    cnt_nxt   = bus.seg_count;
                    idx_nxt   = '0;
                    err_nxt   = 1'b0;
                    state_nxt = (bus.seg_count == 5'd0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                tx_nxt = bus.seg_end_x;
                ty_nxt = bus.seg_end_y;
                if (bus.seg_start_x != pos_x || bus.seg_start_y != pos_y) err_nxt = 1'b1;
                if (bus.seg_pen_down != pen) begin
                    pen_nxt    = bus.seg_pen_down;
                    settle_nxt = SW'(PEN_SETTLE);
                    state_nxt  = S_PEN;
                end else begin
                    state_nxt  = S_MOVE;
                end
            end
            S_PEN: begin
                if (tick) begin
                    settle_nxt = settle - SW'(1);
                    if (settle == SW'(1)) state_nxt = S_MOVE;
                end
            end
            S_MOVE: begin
                if (tick && pos_x != tgt_x) begin
                    dx_nxt = (tgt_x > pos_x);
                    sx_nxt = 1'b1;
                    px_nxt = dx_nxt ? pos_x + 8'd1 : pos_x - 8'd1;
                end
                if (tick && pos_y != tgt_y) begin
                    dy_nxt = (tgt_y > pos_y);
                    sy_nxt = 1'b1;
                    py_nxt = dy_nxt ? pos_y + 8'd1 : pos_y - 8'd1;
                end
                if (px_nxt == tgt_x && py_nxt == tgt_y) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                if (seg_idx + 5'd1 == cnt_lat) begin
                    state_nxt = S_DONE;
                end else begin
                    idx_nxt   = seg_idx + 5'd1;
                    state_nxt = S_LOAD;
                end
            end
            S_DONE: begin
                done_nxt  = 1'b1;
                idx_nxt   = '0;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.seg_idx = seg_idx;
    assign bus.seg_en  = busy;
    assign bus.busy    = busy;
    assign bus.pos_x   = pos_x;
    assign bus.pos_y   = pos_y;
    assign bus.pen     = pen;
    assign bus.step_x  = step_x;
    assign bus.step_y  = step_y;
    assign bus.dir_x   = dir_x;
    assign bus.dir_y   = dir_y;
    assign bus.err     = err;
    assign bus.done    = done;
endmodule

// File: doc/stroke_player.md
# stroke_player

Sequencer and motion generator at the consuming end of the digit stroke tables. It walks a stroke table's segment index and reads back each segment's start point, end point and pen state. For each segment it raises or lowers the pen, waits for the pen to settle, then steps the X/Y axes one unit per motion tick until the segment end point is reached. Its outputs drive the stepper and pen-servo drivers of the plotter.

## Interface
- `TICK_DIV`, default 100000: clk cycles per motion tick (≥2).
- `PEN_SETTLE`, default 50: motion ticks to wait after any pen state change (≥1).
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: one-cycle pulse that begins playback. Ignored while `busy`.
- `seg_count`, input, 5: number of segments in the table. Sampled on `start`.
- `seg_idx`, output, 5: segment index presented to the stroke table. Registered.
- `seg_en`, output, 1: enable for the stroke table. High while `busy`.
- `seg_start_x`, `seg_start_y`, `seg_end_x`, `seg_end_y`, input, 8 each: segment fields. Combinational from `seg_idx`.
- `seg_pen_down`, input, 1: pen state for the segment.
- `pos_x`, `pos_y`, output, 8 each: current head position.
- `pen`, output, 1: pen-servo command; 1 = pen down.
- `step_x`, `step_y`, output, 1 each: one-clk step pulses.
- `dir_x`, `dir_y`, output, 1 each: step direction; 1 = increment.
- `busy`, output, 1: playback in progress.
- `done`, output, 1: one-cycle pulse when playback completes.
- `err`, output, 1: sticky flag; segment start did not match the current position.

## Operation
- Reset values: `seg_idx`=0, `seg_en`=0, `pos_x`=`pos_y`=0, `pen`=0, `step_*`=0, `dir_*`=0, `busy`=0, `done`=0, `err`=0. The tick divider and settle counter are cleared; state is IDLE.
- A free-running tick divider runs only while `busy`. It pulses `tick` every `TICK_DIV` clks and restarts at 0 on entry to LOAD.
- IDLE
  - On `start`: latch `seg_count`, set `seg_idx`=0, clear `err`, go to LOAD.
  - If `seg_count`=0: skip LOAD and go directly to DONE.
- LOAD (1 cycle)
  - Latch the end point and pen state from the table inputs.
  - If (`seg_start_x`,`seg_start_y`) ≠ (`pos_x`,`pos_y`), set `err`. Motion still proceeds from the current position.
  - If the latched pen state ≠ `pen`: update `pen`, load the settle counter with `PEN_SETTLE`, go to PEN.
  - Otherwise go to MOVE.
- PEN
  - Decrement the settle counter on each `tick`.
  - When it reaches 0, go to MOVE.
- MOVE
  - On each `tick`, each axis with position ≠ target independently:
    - sets its `dir` (1 if target > position);
    - pulses `step` for exactly that clk;
    - moves its position ±1 in the same cycle.
  - Both axes may step on the same tick (diagonal travel).
  - When both axes are at target, go to NEXT. A zero-length segment goes to NEXT without emitting any step.
- NEXT (1 cycle)
  - If `seg_idx`+1 = latched count, go to DONE.
  - Else increment `seg_idx` and go to LOAD.
- DONE (1 cycle)
  - Pulse `done`, drop `busy` and `seg_en`, return to IDLE.
  - `pos_*`, `pen` and `err` hold their values; `seg_idx` resets to 0.
- Position arithmetic is unsigned 8-bit. A step never wraps: movement is always toward the target, so 0↔255 crossing cannot occur.
- `dir_*` holds its last value between steps.

## Timing
- `start` → `busy`/`seg_en` high on the next clk edge.
- First LOAD occurs 1 cycle after `start`. The table fields must be valid combinationally in that cycle.
- First step occurs no earlier than `TICK_DIV` clks after LOAD entry without a pen change. With a pen change it occurs no earlier than (`PEN_SETTLE`+1)·`TICK_DIV` clks.
- An axis-aligned segment of length L takes exactly L ticks in MOVE. A general segment takes max(|dx|,|dy|) ticks.
- `done` is asserted 2 cycles after the final step: NEXT, then DONE.
- Reset asserted mid-playback: all outputs return to reset values immediately (asynchronously), including `pen`=0. The in-flight segment is abandoned.
- A `start` pulse arriving while `busy` has no effect.
- A `start` pulse in the same cycle as `done` is ignored. `start` is accepted only from IDLE.

## Test plan
All scenarios use `TICK_DIV`=4 and `PEN_SETTLE`=2.
- Reset: `rst` pulsed mid-MOVE → all outputs 0 within the same cycle; after release, `busy`=0 and `pos`=(0,0).
- Single segment, pen-up travel (0,0)→(3,2), `seg_count`=1:
  - exactly 3 `step_x` and 2 `step_y` pulses with `dir_x`=`dir_y`=1;
  - the first 2 ticks step both axes;
  - final position (3,2), `pen`=0, `err`=0, one `done` pulse.
- Three-segment table (0,0)→(2,1) pen up, (2,1)→(2,4) pen down, (2,4)→(5,4) pen down:
  - `pen` rises before segment 1's first step;
  - `seg_idx` sequence is 0,1,2;
  - total 5 `step_x` and 4 `step_y` pulses;
  - ends at (5,4) with `pen`=1.
- Decreasing move, start position (5,5), segment (5,5)→(5,2) → 3 `step_y` pulses with `dir_y`=0, ending at (5,2).
- Mismatched segment start (10,10) while at (0,0), end (1,0) → `err`=1, exactly one `step_x`, and `err` still 1 after `done`.
- `seg_count`=0 → `done` 2 cycles after `start` with no steps. A second `start` while `busy` is ignored: `seg_idx` does not restart.
